// File: rtl/mgpu_pkg.sv
// Shared definitions for the matrix GPU front end: data widths, default W value, loader states.
`default_nettype none

package mgpu_pkg;

    localparam int VTX_W  = 16;
    localparam int COL_W  = 64;
    localparam int MTRX_W = 256;

    localparam logic [VTX_W-1:0] W_ONE_DEFAULT = 16'h0020;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        HOLD = 1'b1
    } loader_state_t;

endpackage

`default_nettype wire

// File: rtl/vtx_col_pack.sv
// Packs one vertex into a 64-bit homogeneous column {X, Y, Z, W}; invalid columns are all-zero.
`default_nettype none

module vtx_col_pack
    import mgpu_pkg::*;
#(
    parameter logic [VTX_W-1:0] W_ONE = W_ONE_DEFAULT
) (
    input  logic [VTX_W-1:0] x,
    input  logic [VTX_W-1:0] y,
    input  logic [VTX_W-1:0] z,
    input  logic             valid,
    output logic [COL_W-1:0] col
);

    always_comb begin
        col = '0;
        if (valid) begin
            col = {x, y, z, W_ONE};
        end
    end

endmodule

`default_nettype wire

// File: rtl/vertex_batch_loader.sv
// Groups vertices in fours into a packed column-major 4x4 matrix with W insertion and backpressure.
// Build option: define BATCH_PAD_EN to let vtx_last close a batch early with zero-padded columns.
`default_nettype none

module vertex_batch_loader
    import mgpu_pkg::*;
#(
    parameter logic [VTX_W-1:0] W_ONE = W_ONE_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vtx_valid,
    output logic              vtx_ready,
    input  logic [VTX_W-1:0]  vtx_x,
    input  logic [VTX_W-1:0]  vtx_y,
    input  logic [VTX_W-1:0]  vtx_z,
    input  logic              vtx_last,
    output logic              mtrx_valid,
    input  logic              mtrx_ready,
    output logic [MTRX_W-1:0] mtrx_data,
    output logic [2:0]        mtrx_count,
    output logic              busy
);

`ifdef BATCH_PAD_EN
    localparam logic PAD_EN = 1'b1;
`else
    localparam logic PAD_EN = 1'b0;
`endif

    loader_state_t     state, state_next;
    logic [1:0]        fill_cnt;
    logic [COL_W-1:0]  slots [0:2];
    logic [COL_W-1:0]  cur_col;
    logic [MTRX_W-1:0] batch;
    logic [2:0]        batch_cnt;
    logic [MTRX_W-1:0] held_data;
    logic [2:0]        held_cnt;
    logic              accept, complete, transfer, out_free;
    logic              load_batch, load_held, park_batch;

    vtx_col_pack #(.W_ONE(W_ONE)) u_pack (
        .x     (vtx_x),
        .y     (vtx_y),
        .z     (vtx_z),
        .valid (1'b1),
        .col   (cur_col)
    );

    assign vtx_ready = (state == FILL) && !rst;
    assign accept    = vtx_valid && vtx_ready;
    assign complete  = accept && ((fill_cnt == 2'd3) || (PAD_EN && vtx_last));
    assign transfer  = mtrx_valid && mtrx_ready;
    assign out_free  = !mtrx_valid || mtrx_ready;
    assign busy      = (fill_cnt != 2'd0) || mtrx_valid;

    // Stored slots, then the arriving vertex, then zero padding for unfilled columns.
    always_comb begin
        batch = '0;
        for (int k = 0; k < 3; k++) begin
            if (2'(k) < fill_cnt) begin
                batch[MTRX_W-1-COL_W*k -: COL_W] = slots[k];
            end else if (2'(k) == fill_cnt) begin
                batch[MTRX_W-1-COL_W*k -: COL_W] = cur_col;
            end
        end
        if (fill_cnt == 2'd3) begin
            batch[COL_W-1:0] = cur_col;
        end
        batch_cnt = {1'b0, fill_cnt} + 3'd1;
    end

    always_comb begin
        state_next = state;
        load_batch = 1'b0;
        load_held  = 1'b0;
        park_batch = 1'b0;
        case (state)
            FILL: begin
                if (complete) begin
                    if (out_free) begin
                        load_batch = 1'b1;
                    end else begin
                        park_batch = 1'b1;
                        state_next = HOLD;
                    end
                end
            end
            HOLD: begin
                if (transfer) begin
                    load_held  = 1'b1;
                    state_next = FILL;
                end
            end
            default: state_next = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= FILL;
            fill_cnt   <= 2'd0;
            held_data  <= '0;
            held_cnt   <= 3'd0;
            mtrx_valid <= 1'b0;
            mtrx_data  <= '0;
            mtrx_count <= 3'd0;
            for (int k = 0; k < 3; k++) begin
                slots[k] <= '0;
            end
        end else begin
            state <= state_next;
            if (complete) begin
                fill_cnt <= 2'd0;
            end else if (accept) begin
                fill_cnt <= fill_cnt + 2'd1;
            end
            for (int k = 0; k < 3; k++) begin
                if (accept && !complete && (fill_cnt == 2'(k))) begin
                    slots[k] <= cur_col;
                end
            end
            if (park_batch) begin
                held_data <= batch;
                held_cnt  <= batch_cnt;
            end
            if (load_batch) begin
                mtrx_valid <= 1'b1;
                mtrx_data  <= batch;
                mtrx_count <= batch_cnt;
            end else if (load_held) begin
                mtrx_valid <= 1'b1;
                mtrx_data  <= held_data;
                mtrx_count <= held_cnt;
            end else if (transfer) begin
                mtrx_valid <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_vertex_batch_loader.sv
// Scoreboard bench for vertex_batch_loader: batches, backpressure, streaming, early close, reset.
`default_nettype none

module tb_vertex_batch_loader;

`ifdef BATCH_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif
    localparam logic [15:0] WV = 16'h0020;

    typedef struct {
        logic [255:0] d;
        logic [2:0]   c;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         vtx_valid = 1'b0;
    logic         vtx_ready;
    logic [15:0]  vtx_x = '0, vtx_y = '0, vtx_z = '0;
    logic         vtx_last = 1'b0;
    logic         mtrx_valid;
    logic         mtrx_ready = 1'b0;
    logic [255:0] mtrx_data;
    logic [2:0]   mtrx_count;
    logic         busy;

    int checks = 0;
    int errors = 0;
    int n_out  = 0;
    int stl;
    int base;
    exp_t q[$];
    logic [63:0] mcols [0:3];
    int mn = 0;
    logic         hold_prev = 1'b0;
    logic [255:0] prev_d;
    logic [2:0]   prev_c;

    vertex_batch_loader dut (
        .clk        (clk),
        .rst        (rst),
        .vtx_valid  (vtx_valid),
        .vtx_ready  (vtx_ready),
        .vtx_x      (vtx_x),
        .vtx_y      (vtx_y),
        .vtx_z      (vtx_z),
        .vtx_last   (vtx_last),
        .mtrx_valid (mtrx_valid),
        .mtrx_ready (mtrx_ready),
        .mtrx_data  (mtrx_data),
        .mtrx_count (mtrx_count),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: columns accumulate in arrival order; a closed batch is zero-padded.
    task automatic model_push(input logic [15:0] x, y, z, input bit last);
        exp_t e;
        mcols[mn] = {x, y, z, WV};
        mn++;
        if (mn == 4 || (PAD && last)) begin
            e.d = '0;
            for (int k = 0; k < 4; k++) begin
                if (k < mn) e.d[255-64*k -: 64] = mcols[k];
            end
            e.c = 3'(mn);
            q.push_back(e);
            mn = 0;
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the accepting rising edge.
    task automatic send(input logic [15:0] x, y, z, input bit last, output int stalls);
        vtx_x = x; vtx_y = y; vtx_z = z; vtx_last = last; vtx_valid = 1'b1;
        stalls = 0;
        while (!vtx_ready && stalls < 50) begin
            @(negedge clk);
            stalls++;
        end
        if (!vtx_ready) begin
            check("send_timeout", 256'(vtx_ready), 256'd1);
            vtx_valid = 1'b0;
        end else begin
            @(posedge clk);
            model_push(x, y, z, last);
            @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        vtx_valid = 1'b0;
        vtx_last  = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic drain();
        int t = 0;
        while (q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("drain_empty", 256'(q.size()), 256'd0);
    endtask

    always @(negedge clk) begin
        #1;
        if (rst) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                check("stable_valid", 256'(mtrx_valid), 256'd1);
                check("stable_data", mtrx_data, prev_d);
                check("stable_count", 256'(mtrx_count), 256'(prev_c));
            end
            if (mtrx_valid && mtrx_ready) begin
                if (q.size() == 0) begin
                    check("matrix_expected", 256'(q.size()), 256'd1);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("mtrx_data", mtrx_data, e.d);
                    check("mtrx_count", 256'(mtrx_count), 256'(e.c));
                    n_out++;
                end
            end
            hold_prev = mtrx_valid && !mtrx_ready;
            prev_d    = mtrx_data;
            prev_c    = mtrx_count;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] full_exp;
        full_exp = {64'h0001_0002_0003_0020, 64'h0004_0005_0006_0020,
                    64'h0007_0008_0009_0020, 64'hFFFF_FFFE_FFFD_0020};
        #1;
        check("rst_ready", 256'(vtx_ready), 256'd0);
        check("rst_valid", 256'(mtrx_valid), 256'd0);
        check("rst_data", mtrx_data, 256'd0);
        check("rst_count", 256'(mtrx_count), 256'd0);
        check("rst_busy", 256'(busy), 256'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rel_ready", 256'(vtx_ready), 256'd1);
        @(negedge clk);

        // Full batch with latency and hold-after-transfer
        mtrx_ready = 1'b1;
        send(16'd1, 16'd2, 16'd3, 1'b0, stl);
        send(16'd4, 16'd5, 16'd6, 1'b0, stl);
        send(16'd7, 16'd8, 16'd9, 1'b0, stl);
        check("lat_early", 256'(mtrx_valid), 256'd0);
        send(-16'sd1, -16'sd2, -16'sd3, 1'b0, stl);
        check("lat_valid", 256'(mtrx_valid), 256'd1);
        check("full_data", mtrx_data, full_exp);
        check("full_count", 256'(mtrx_count), 256'd4);
        idle(2);
        check("valid_drop", 256'(mtrx_valid), 256'd0);
        check("data_hold", mtrx_data, full_exp);

        // Backpressure: two batches fill output and hold register, then drain
        mtrx_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            send(16'(100 + i), 16'(200 + i), 16'(300 + i), 1'b0, stl);
        end
        check("hold_ready", 256'(vtx_ready), 256'd0);
        check("hold_busy", 256'(busy), 256'd1);
        idle(3);
        mtrx_ready = 1'b1;
        for (int i = 8; i < 12; i++) begin
            send(16'(100 + i), 16'(200 + i), 16'(300 + i), 1'b0, stl);
        end
        idle(1);
        drain();

        // Streaming: one vertex per cycle, no stalls, four matrices
        base = n_out;
        for (int i = 0; i < 16; i++) begin
            send(16'($urandom), 16'($urandom), 16'($urandom), 1'b0, stl);
            check("stream_nostall", 256'(stl), 256'd0);
        end
        idle(2);
        drain();
        check("stream_count", 256'(n_out - base), 256'd4);

        // Early close via vtx_last
        send(16'h0A0A, 16'h0B0B, 16'h0C0C, 1'b0, stl);
        send(16'h1A1A, 16'h1B1B, 16'h1C1C, 1'b0, stl);
        send(16'h2A2A, 16'h2B2B, 16'h2C2C, 1'b1, stl);
`ifdef BATCH_PAD_EN
        check("pad_valid", 256'(mtrx_valid), 256'd1);
        check("pad_count", 256'(mtrx_count), 256'd3);
        check("pad_zero", 256'(mtrx_data[63:0]), 256'd0);
`else
        check("nopad_wait", 256'(mtrx_valid), 256'd0);
        send(16'h3A3A, 16'h3B3B, 16'h3C3C, 1'b0, stl);
        check("nopad_valid", 256'(mtrx_valid), 256'd1);
        check("nopad_count", 256'(mtrx_count), 256'd4);
`endif
        idle(2);
        drain();

        // Transfer coinciding with batch completion
        mtrx_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            send(16'(500 + i), 16'(600 + i), 16'(700 + i), 1'b0, stl);
        end
        check("simul_pending", 256'(mtrx_valid), 256'd1);
        mtrx_ready = 1'b1;
        send(16'd507, 16'd607, 16'd707, 1'b0, stl);
        check("simul_valid", 256'(mtrx_valid), 256'd1);
        check("simul_data", mtrx_data[63:0], 256'({16'd507, 16'd607, 16'd707, WV}));
        idle(2);
        check("simul_drop", 256'(mtrx_valid), 256'd0);
        drain();

        // Reset mid-batch discards the partial batch
        send(16'h0111, 16'h0222, 16'h0333, 1'b0, stl);
        send(16'h0444, 16'h0555, 16'h0666, 1'b0, stl);
        vtx_valid = 1'b0;
        check("pre_rst_busy", 256'(busy), 256'd1);
        rst = 1'b1;
        mn  = 0;
        #1;
        check("mid_rst_valid", 256'(mtrx_valid), 256'd0);
        check("mid_rst_busy", 256'(busy), 256'd0);
        check("mid_rst_ready", 256'(vtx_ready), 256'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_ready", 256'(vtx_ready), 256'd1);
        @(negedge clk);
        base = n_out;
        for (int i = 0; i < 4; i++) begin
            send(16'(16'h0800 + i), 16'(16'h0900 + i), 16'(16'h0A00 + i), 1'b0, stl);
        end
        idle(2);
        drain();
        check("post_rst_count", 256'(n_out - base), 256'd1);

        idle(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
